// File: rtl/instr_mem.sv
// Instruction memory with a sequential program loader and a registered,
// single-cycle-latency fetch port, sequenced by an IDLE/LOAD/READY controller.
module instr_mem #(
  parameter int          DEPTH  = 256,
  parameter int          AW     = 8,
  parameter logic [15:0] HLT_OP = 16'hF000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] iaddr,
  input  logic        rd_en,
  output logic [15:0] instr,
  output logic        instr_vld,
  output logic        addr_err,
  input  logic        ld_start,
  input  logic [15:0] ld_data,
  input  logic        ld_vld,
  input  logic        ld_done,
  output logic        ld_full,
  output logic        ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [16:0]   DEPTH_W  = 17'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] wptr, wptr_nxt, widx;
  logic          wr_en;
  logic          last_word;
  logic          rd_fire;
  logic          in_range;
  logic [15:0]   mem [DEPTH];

  // Full 16-bit compare so that addresses beyond DEPTH never alias onto low words.
  assign in_range = {1'b0, iaddr} < DEPTH_W;

  // A fetch in the same cycle as a load restart is dropped.
  assign rd_fire = (state == READY) && rd_en && !ld_start;

  // NOTE: every signal driven here gets a default first so no latch is inferred
  // on paths that do not mention it.
  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    widx      = wptr;
    wr_en     = 1'b0;
    last_word = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_nxt = LOAD;
          wptr_nxt  = '0;
        end
      end
      LOAD: begin
        wr_en = ld_vld;
        if (ld_start) begin
          // Restart: a word arriving with the restart lands at index 0.
          widx     = '0;
          wptr_nxt = ld_vld ? AW'(1) : '0;
        end else begin
          if (ld_vld) begin
            wptr_nxt = wptr + AW'(1);
          end
          last_word = ld_vld && (wptr == LAST_IDX);
          if (ld_done || last_word) begin
            state_nxt = READY;
          end
        end
      end
      READY: begin
        if (ld_start) begin
          state_nxt = LOAD;
          wptr_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wptr      <= '0;
      instr     <= '0;
      instr_vld <= 1'b0;
      addr_err  <= 1'b0;
      ld_full   <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      wptr      <= wptr_nxt;
      instr_vld <= rd_fire;
      addr_err  <= rd_fire && !in_range;
      ld_full   <= last_word;
      ready     <= (state_nxt == READY);
      if (rd_fire) begin
        instr <= in_range ? mem[iaddr[AW-1:0]] : HLT_OP;
      end
    end
  end

  // NOTE: the storage array has no reset so a program image survives a reset
  // and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[widx] <= ld_data;
    end
  end

endmodule
